// File: rtl/reg_file_sb.sv
// Register file (x0 hardwired to zero) with a per-register scoreboard busy bit and a pending-write count.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module reg_file_sb #(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              SP_IDX   = 2,
    parameter logic [XLEN-1:0] SP_RESET = 32'h80000800,
    localparam int             AW       = $clog2(NREGS),
    localparam int             CW       = $clog2(NREGS) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   readA,
    input  logic [AW-1:0]   readB,
    input  logic            writeEnC,
    input  logic [AW-1:0]   writeC,
    input  logic [XLEN-1:0] writeDataC,
    input  logic            issueEn,
    input  logic [AW-1:0]   issueRd,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic            busyA,
    output logic            busyB,
    output logic [CW-1:0]   pendCount
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_next;
    logic             wr_en;
    logic             iss_en;
    logic             cnt_inc;
    logic             cnt_dec;
    logic             byp_a;
    logic             byp_b;

    // Counter step clamped to [0, NREGS-1] so it can never wrap.
    function automatic logic [CW-1:0] step_count(input logic [CW-1:0] cnt,
                                                 input logic          inc,
                                                 input logic          dec);
        logic [CW-1:0] max_cnt;
        max_cnt = CW'(NREGS - 1);
        if (inc && !dec && cnt != max_cnt) return cnt + 1'b1;
        if (dec && !inc && cnt != '0)      return cnt - 1'b1;
        return cnt;
    endfunction

    assign wr_en  = writeEnC && (writeC != '0);
    assign iss_en = issueEn && (issueRd != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[writeC] <= writeDataC;
        end
    end

    // Issue is applied after writeback so a same-register collision leaves the bit set.
    always_comb begin
        busy_next = busy;
        if (wr_en)  busy_next[writeC]  = 1'b0;
        if (iss_en) busy_next[issueRd] = 1'b1;
    end

    assign cnt_inc = iss_en && !busy[issueRd];
    assign cnt_dec = wr_en && busy[writeC] && !(iss_en && (issueRd == writeC));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= '0;
            pendCount <= '0;
        end else begin
            busy      <= busy_next;
            pendCount <= step_count(pendCount, cnt_inc, cnt_dec);
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign byp_a = reset && wr_en && (readA == writeC);
    assign byp_b = reset && wr_en && (readB == writeC);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    always_comb begin
        A = '0;
        B = '0;
        if (readA != '0) A = byp_a ? writeDataC : regs[readA];
        if (readB != '0) B = byp_b ? writeDataC : regs[readB];
    end

    assign busyA = busy[readA];
    assign busyB = busy[readB];

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of every register.
REQ-002 SHALL have parameter NREGS, default 32, register count including hardwired x0; power of two, 2..64.
REQ-003 SHALL have parameter SP_IDX, default 2, index of the register with a non-zero reset value.
REQ-004 SHALL have parameter SP_RESET, default 32'h80000800, reset value of register SP_IDX.
REQ-005 SHALL have the following ports, where AW = $clog2(NREGS) and CW = $clog2(NREGS)+1:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- readA  in  AW  read port A index.
- readB  in  AW  read port B index.
- writeEnC  in  1  write strobe.
- writeC  in  AW  write index.
- writeDataC  in  XLEN  write data.
- issueEn  in  1  mark destination register as pending.
- issueRd  in  AW  destination register being issued.
- A  out  XLEN  port A data.
- B  out  XLEN  port B data.
- busyA  out  1  register readA has a pending write.
- busyB  out  1  register readB has a pending write.
- pendCount  out  CW  number of registers currently pending.

Function
REQ-006 SHALL hold registers 1..NREGS-1 as XLEN-bit flops; index 0 reads as 0, is never written and is never busy.
REQ-007 SHALL perform the write on a rising clk edge when writeEnC=1 and writeC!=0.
REQ-008 SHALL drive A and B combinationally with zero-cycle latency: index 0 gives 0, otherwise the stored value, subject to REQ-016.
REQ-009 SHALL keep one busy bit per register, scoreboard semantics:
- set on a clk edge when issueEn=1 and issueRd!=0;
- cleared on a clk edge when writeEnC=1 and writeC equals that index;
- no other effect on the busy bit.
REQ-010 SHALL let set win when issueEn/issueRd and writeEnC/writeC target the same register on the same edge; the data write still occurs and the busy bit ends at 1.
REQ-011 SHALL leave a register's busy bit at 1 when issueEn targets an already-busy register; pendCount SHALL not change.
REQ-012 SHALL leave a register's busy bit at 0 when writeEnC targets a non-busy register; pendCount SHALL not change.
REQ-013 SHALL drive busyA and busyB combinationally from the current busy bits, with no forwarding of same-cycle issue or writeback.
REQ-014 SHALL hold pendCount as a registered count equal to the population of the busy bits after every edge:
- +1 on a set of a clear bit;
- -1 on a clear of a set bit;
- net 0 when both events hit different registers on one edge.
REQ-015 SHALL never let pendCount exceed NREGS-1 or go below 0; no wrap.

Reset
REQ-017 SHALL, while reset=0 and asynchronously to clk:
- force all registers to 0 except register SP_IDX, which takes SP_RESET;
- clear all busy bits and pendCount.
REQ-018 SHALL ignore writeEnC and issueEn while reset=0; a write or issue in flight at reset assertion is discarded.
REQ-019 SHALL drive, under reset, A=B=0 except for reads of SP_IDX (SP_RESET), and busyA=busyB=0.
REQ-020 SHALL apply the first write or issue on the first rising clk edge after reset deasserts.

Configuration
REQ-016 SHALL support macro REG_FILE_BYPASS_EN:
- defined: when writeEnC=1, writeC!=0 and readA (or readB) equals writeC, A (or B) returns writeDataC in the same cycle;
- undefined: A and B return the stored value until the edge;
- busy outputs are unaffected either way.

Verification
REQ-021 SHALL cover: reset pulse, then readA=2, readB=0 -> A=32'h80000800, B=0, pendCount=0.
REQ-022 SHALL cover: write x5=32'hDEADBEEF, readA=5 in the same cycle -> A=32'hDEADBEEF with REG_FILE_BYPASS_EN, A=0 without it; next cycle A=32'hDEADBEEF in both builds.
REQ-023 SHALL cover: issue x7, x9, then x7 again -> pendCount 1,2,2; busyA=1 with readA=7; then write x7 -> busy7=0, pendCount=1.
REQ-024 SHALL cover: same edge issueRd=3 and writeC=3, data 32'h1234 -> x3=32'h1234, busy3=1, pendCount +1.
REQ-025 SHALL cover: write x0=32'hFFFFFFFF and issue x0 -> A(readA=0)=0, busyA=0, pendCount unchanged.
REQ-026 SHALL cover: x4 busy with pendCount=1, reset asserted mid-cycle -> busy4, pendCount and x4 at 0 immediately, before any clk edge.
